// File: rtl/idu_ir_freelist_if.sv
// idu_ir_freelist_if: rename allocation and RTU retire/release signals
//    master: rename/RTU side drives alloc_req, rtu_retire_vld, rtu_release_vld, rtu_release_preg
//    slave:  free list drives alloc_vld, alloc_preg
interface idu_ir_freelist_if #(parameter int PREG_W = 6);
   logic              alloc_req;
   logic              alloc_vld;
   logic [PREG_W-1:0] alloc_preg;
   logic              rtu_retire_vld;
   logic              rtu_release_vld;
   logic [PREG_W-1:0] rtu_release_preg;
   modport master (output alloc_req, rtu_retire_vld, rtu_release_vld, rtu_release_preg,
                   input alloc_vld, alloc_preg);
   modport slave (input alloc_req, rtu_retire_vld, rtu_release_vld, rtu_release_preg,
                  output alloc_vld, alloc_preg);
endinterface

// File: rtl/idu_ir_freelist.sv
// idu_ir_freelist: physical-register free list with committed pointer for one-cycle flush recovery
//    clk, rst_clk (sync, active-high), rtu_global_flush, y_idu_ir_stall_ctrl
//    fl: alloc_req/alloc_vld/alloc_preg, rtu_retire_vld, rtu_release_vld/rtu_release_preg
//    freelist_empty, freelist_cnt (0..FL_DEPTH), overflow_err (sticky)
//    Optional macro IDU_FREELIST_EMPTY_BYPASS_EN: forward a release straight to allocation when empty
module idu_ir_freelist #(
   parameter int PREG_NUM = 64,
   parameter int PREG_W   = 6,
   parameter int ARCH_NUM = 32,
   parameter int FL_DEPTH = 32,
   parameter int PTR_W    = 5
) (
   input  logic             clk,
   input  logic             rst_clk,
   input  logic             rtu_global_flush,
   input  logic             y_idu_ir_stall_ctrl,
   idu_ir_freelist_if.slave fl,
   output logic             freelist_empty,
   output logic [PTR_W:0]   freelist_cnt,
   output logic             overflow_err
);
   logic [PREG_W-1:0] mem [FL_DEPTH];
   logic [PTR_W:0]    rd_ptr, wr_ptr, cmt_ptr, cmt_ptr_next;
   logic              grant, byp, full, wr_en;

   assign freelist_cnt   = wr_ptr - rd_ptr;
   assign freelist_empty = wr_ptr == rd_ptr;
   // count never exceeds FL_DEPTH, so its top bit alone means full
   assign full           = freelist_cnt[PTR_W];
   assign wr_en          = fl.rtu_release_vld & ~full;

   always_comb begin
      grant = fl.alloc_req & ~y_idu_ir_stall_ctrl & ~rtu_global_flush & ~rst_clk;
`ifdef IDU_FREELIST_EMPTY_BYPASS_EN
      byp = grant & freelist_empty & fl.rtu_release_vld;
`else
      byp = 1'b0;
`endif
      fl.alloc_vld  = grant & (~freelist_empty | byp);
      fl.alloc_preg = byp ? fl.rtu_release_preg : mem[rd_ptr[PTR_W-1:0]];
      // a retire with nothing speculatively allocated is illegal and is ignored
      cmt_ptr_next  = cmt_ptr + (PTR_W+1)'(fl.rtu_retire_vld & (cmt_ptr != rd_ptr));
   end

   always_ff @(posedge clk) begin
      if (rst_clk) begin
         rd_ptr       <= '0;
         cmt_ptr      <= '0;
         wr_ptr       <= (PTR_W+1)'(FL_DEPTH);
         overflow_err <= 1'b0;
         for (int i = 0; i < FL_DEPTH; i++) mem[i] <= PREG_W'((ARCH_NUM + i) % PREG_NUM);
      end else begin
         rd_ptr       <= rtu_global_flush ? cmt_ptr_next : rd_ptr + (PTR_W+1)'(fl.alloc_vld);
         cmt_ptr      <= cmt_ptr_next;
         overflow_err <= overflow_err | (fl.rtu_release_vld & full);
         if (wr_en) begin
            mem[wr_ptr[PTR_W-1:0]] <= fl.rtu_release_preg;
            wr_ptr                 <= wr_ptr + (PTR_W+1)'(1);
         end
      end
   end
endmodule

// File: tb/tb_idu_ir_freelist.sv
// tb_idu_ir_freelist: vector table, corner sequences and random run against a queue-based free-list model
module tb_idu_ir_freelist;
   logic       clk = 1'b0;
   logic       rst_clk = 1'b1;
   logic       rtu_global_flush = 1'b0;
   logic       y_idu_ir_stall_ctrl = 1'b0;
   logic       freelist_empty;
   logic [5:0] freelist_cnt;
   logic       overflow_err;
   int         checks = 0;
   int         failures = 0;

   idu_ir_freelist_if #(.PREG_W(6)) fl();

   idu_ir_freelist dut (
      .clk(clk), .rst_clk(rst_clk), .rtu_global_flush(rtu_global_flush),
      .y_idu_ir_stall_ctrl(y_idu_ir_stall_ctrl), .fl(fl),
      .freelist_empty(freelist_empty), .freelist_cnt(freelist_cnt), .overflow_err(overflow_err)
   );

   always #5 clk = ~clk;

   // model: free pregs in FIFO order, plus pregs allocated but not yet retired
   logic [5:0] free_q[$];
   logic [5:0] spec_q[$];
   bit         m_ovf;

   bit         a_vld, a_empty, a_ovf;
   logic [5:0] a_preg;
   int         a_cnt;

   typedef struct {
      bit req, stall, flush, ret, rel; logic [5:0] rp;
      bit vld; logic [5:0] preg; int cnt; bit empty, ovf;
   } vec_t;
   vec_t tbl[11];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      free_q.delete();
      spec_q.delete();
      for (int i = 0; i < 32; i++) free_q.push_back(6'(32 + i));
      m_ovf = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_clk = 1'b1;
      fl.alloc_req = 1'b1; fl.rtu_retire_vld = 1'b0; fl.rtu_release_vld = 1'b0; fl.rtu_release_preg = '0;
      rtu_global_flush = 1'b0; y_idu_ir_stall_ctrl = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rst_alloc_vld", int'(fl.alloc_vld), 0);
      check("rst_cnt", int'(freelist_cnt), 32);
      check("rst_empty", int'(freelist_empty), 0);
      check("rst_ovf", int'(overflow_err), 0);
      rst_clk = 1'b0;
      fl.alloc_req = 1'b0;
      model_reset();
   endtask

   // call at a negedge; returns at the following negedge
   task automatic step(input bit req, stall, flush, ret, rel, input logic [5:0] rp);
      bit e_vld, byp, had_spec;
      logic [5:0] e_preg;
      int fsz;
      fl.alloc_req = req; y_idu_ir_stall_ctrl = stall; rtu_global_flush = flush;
      fl.rtu_retire_vld = ret; fl.rtu_release_vld = rel; fl.rtu_release_preg = rp;
      #1;
      fsz = free_q.size();
`ifdef IDU_FREELIST_EMPTY_BYPASS_EN
      byp = req && !stall && !flush && rel && fsz == 0;
`else
      byp = 0;
`endif
      e_vld  = req && !stall && !flush && (fsz > 0 || byp);
      e_preg = byp ? rp : (fsz > 0 ? free_q[0] : 6'd0);
      a_vld = fl.alloc_vld; a_preg = fl.alloc_preg; a_cnt = int'(freelist_cnt);
      a_empty = freelist_empty; a_ovf = overflow_err;
      check("alloc_vld", int'(a_vld), int'(e_vld));
      if (e_vld) check("alloc_preg", int'(a_preg), int'(e_preg));
      check("cnt", a_cnt, fsz);
      check("empty", int'(a_empty), int'(fsz == 0));
      check("ovf", int'(a_ovf), int'(m_ovf));
      @(posedge clk);
      had_spec = spec_q.size() > 0;
      if (e_vld) spec_q.push_back(byp ? rp : free_q.pop_front());
      if (ret && had_spec) void'(spec_q.pop_front());
      if (flush) begin
         free_q = {spec_q, free_q};
         spec_q.delete();
      end
      if (rel && !byp) begin
         if (fsz < 32) free_q.push_back(rp);
         else m_ovf = 1;
      end
      @(negedge clk);
   endtask

   initial begin
      tbl[0]  = '{1,0,0,0,0,6'd0, 1,6'd32,32,0,0};
      tbl[1]  = '{1,0,0,0,0,6'd0, 1,6'd33,31,0,0};
      tbl[2]  = '{1,0,0,0,0,6'd0, 1,6'd34,30,0,0};
      tbl[3]  = '{0,0,0,1,0,6'd0, 0,6'd0, 29,0,0};
      tbl[4]  = '{1,0,1,0,0,6'd0, 0,6'd0, 29,0,0};
      tbl[5]  = '{1,0,0,0,0,6'd0, 1,6'd33,31,0,0};
      tbl[6]  = '{1,1,0,0,1,6'd7, 0,6'd0, 30,0,0};
      tbl[7]  = '{1,1,0,0,1,6'd8, 0,6'd0, 31,0,0};
      tbl[8]  = '{0,0,0,0,1,6'd9, 0,6'd0, 32,0,0};
      tbl[9]  = '{0,0,0,0,0,6'd0, 0,6'd0, 32,0,1};
      tbl[10] = '{1,0,0,0,0,6'd0, 1,6'd34,32,0,1};

      do_reset();
      foreach (tbl[k]) begin
         step(tbl[k].req, tbl[k].stall, tbl[k].flush, tbl[k].ret, tbl[k].rel, tbl[k].rp);
         check($sformatf("tbl%0d_vld", k), int'(a_vld), int'(tbl[k].vld));
         if (tbl[k].vld) check($sformatf("tbl%0d_preg", k), int'(a_preg), int'(tbl[k].preg));
         check($sformatf("tbl%0d_cnt", k), a_cnt, tbl[k].cnt);
         check($sformatf("tbl%0d_ovf", k), int'(a_ovf), int'(tbl[k].ovf));
      end

      do_reset();
      for (int i = 0; i < 32; i++) begin
         step(1, 0, 0, 0, 0, 6'd0);
         check("drain_preg", int'(a_preg), 32 + i);
      end
      step(1, 0, 0, 0, 1, 6'd5);
`ifdef IDU_FREELIST_EMPTY_BYPASS_EN
      check("byp_vld", int'(a_vld), 1);
      check("byp_preg", int'(a_preg), 5);
      check("byp_cnt_after", int'(freelist_cnt), 0);
`else
      check("empty_rel_vld", int'(a_vld), 0);
      check("empty_rel_cnt_after", int'(freelist_cnt), 1);
      step(1, 0, 0, 0, 0, 6'd0);
      check("empty_rel_preg", int'(a_preg), 5);
`endif

      do_reset();
      step(1, 0, 0, 0, 0, 6'd0);
      for (int i = 0; i < 40; i++) begin
         step(1, 0, 0, 1, 1, 6'((i * 7) % 64));
         check("wrap_cnt", a_cnt, 31);
         if (i >= 31) check("wrap_fifo", int'(a_preg), ((i - 31) * 7) % 64);
      end

      do_reset();
      for (int i = 0; i < 3000; i++) begin
         bit ret, rel;
         if ($urandom_range(0, 499) == 0) do_reset();
         ret = spec_q.size() > 0 && $urandom_range(0, 1) == 1;
         rel = free_q.size() + spec_q.size() < 32 && $urandom_range(0, 1) == 1;
         step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
              ret, rel, 6'($urandom_range(0, 63)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/idu_ir_freelist.md
Name: idu_ir_freelist

Overview:
- Physical-register free list for the IDU rename stage.
- Supplies one free preg per cycle to the rename map-update path, which consumes it as the new destination mapping.
- Reclaims old pregs released by the RTU at retire.
- Keeps a committed read pointer so that a global flush restores every speculatively allocated preg in one cycle.

Parameters:
- PREG_NUM, 64, total physical registers.
- PREG_W, 6, preg index width (log2 PREG_NUM).
- ARCH_NUM, 32, architectural registers, mapped to pregs 0..ARCH_NUM-1 at reset.
- FL_DEPTH, 32, free-list entries (PREG_NUM-ARCH_NUM); must be a power of two.
- PTR_W, 5, log2 FL_DEPTH; pointers are PTR_W+1 bits (extra wrap bit).

Ports:
- clk  in  1  clock.
- rst_clk  in  1  synchronous reset, active-high.
- rtu_global_flush  in  1  global flush; restore speculative allocations.
- y_idu_ir_stall_ctrl  in  1  IR stage stall; blocks allocation only.
- alloc_req  in  1  rename wants a new destination preg this cycle.
- alloc_vld  out  1  allocation granted this cycle.
- alloc_preg  out  PREG_W  granted preg.
- freelist_empty  out  1  no free entries.
- freelist_cnt  out  PTR_W+1  free entries, 0..FL_DEPTH.
- rtu_retire_vld  in  1  one preg-allocating instruction retired; advances committed pointer.
- rtu_release_vld  in  1  old preg returned to the list.
- rtu_release_preg  in  PREG_W  preg being returned.
- overflow_err  out  1  sticky: release attempted while full.

Behaviour:
Reset (synchronous, rst_clk=1 at posedge clk):
- mem[i] = ARCH_NUM+i for i in 0..FL_DEPTH-1.
- rd_ptr=0, cmt_ptr=0, wr_ptr=FL_DEPTH (wrap bit set, index 0), i.e. full.
- overflow_err=0.
- Resulting outputs: freelist_cnt=FL_DEPTH, freelist_empty=0, alloc_vld=0 while in reset.
- Reset mid-operation discards all state and returns to the values above.

Combinational outputs:
- freelist_cnt = wr_ptr - rd_ptr (modulo 2^(PTR_W+1)).
- freelist_empty = (wr_ptr == rd_ptr).
- alloc_preg = mem[rd_ptr[PTR_W-1:0]]; 0-latency read, valid only when alloc_vld=1.
- alloc_vld = alloc_req & !freelist_empty & !y_idu_ir_stall_ctrl & !rtu_global_flush & !rst_clk.

Sequential behaviour, priority per cycle:
- Allocation: if alloc_vld, rd_ptr <= rd_ptr+1.
- Flush: if rtu_global_flush, rd_ptr <= cmt_ptr_next, where cmt_ptr_next = cmt_ptr + rtu_retire_vld. Flush overrides allocation.
- Retire: if rtu_retire_vld, cmt_ptr <= cmt_ptr+1. Processed regardless of stall or flush.
  - Retire with cmt_ptr == rd_ptr is an illegal protocol condition; ignore it (cmt_ptr holds).
- Release: if rtu_release_vld and freelist_cnt < FL_DEPTH, then mem[wr_ptr index] <= rtu_release_preg and wr_ptr <= wr_ptr+1.
  - Processed regardless of stall or flush; the written entry is visible from the next cycle.
  - Release while freelist_cnt == FL_DEPTH: write dropped, overflow_err <= 1, held until reset.

Boundary conditions:
- Alloc and release in the same cycle: both pointers move; count unchanged.
- Empty and release in the same cycle: alloc_vld=0 (no bypass unless the optional feature is enabled); count becomes 1 next cycle.
- Full and alloc plus release in the same cycle: still counts as full at decision time; release is dropped and flags overflow. Correct usage never reaches this.
- Pointers wrap naturally at 2^(PTR_W+1); the index is the low PTR_W bits.

Optional Feature:
- Macro: IDU_FREELIST_EMPTY_BYPASS_EN.
- Enabled: when freelist_empty=1, rtu_release_vld=1 and alloc_req can otherwise be granted (no stall, no flush), then:
  - alloc_vld=1 and alloc_preg=rtu_release_preg.
  - The entry is written and consumed in the same cycle: wr_ptr and rd_ptr both increment, count stays 0.
- Disabled: no bypass; alloc_vld=0 whenever freelist_empty=1.

Test Plan:
- Reset then 32 consecutive alloc_req with no stall -> alloc_preg 32,33,...,63, alloc_vld=1 each cycle. 33rd request -> alloc_vld=0, freelist_empty=1, freelist_cnt=0.
- After reset, 3 allocs (32,33,34), 1 retire, then flush -> rd_ptr restored to 1, freelist_cnt=31, next alloc returns 33.
- Empty list, release preg 5 -> next cycle freelist_cnt=1, alloc returns 5. With IDU_FREELIST_EMPTY_BYPASS_EN, alloc in the release cycle returns 5 with alloc_vld=1 and count stays 0.
- y_idu_ir_stall_ctrl=1 with alloc_req=1 and a release of preg 7 at count 31 -> alloc_vld=0, count becomes 32, rd_ptr unchanged.
- Full list (reset state) plus release of preg 9 -> overflow_err=1 and sticky, freelist_cnt stays 32. Assert rst_clk -> overflow_err=0 and initial contents restored.
- Wrap: 40 alloc/release pairs cycling preg IDs -> pointers wrap past 31, alloc order follows release FIFO order, freelist_cnt stays constant.
